// File: rtl/dmem_pkg.sv
// Shared types and helpers for the latency-modelled data memory.
package dmem_pkg;

    // Request sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of byte-offset address bits covered by one line
    function automatic int offset_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/dmem_word_merge.sv
// Combinational per-32-bit-word merge of a new line into an old line.
module dmem_word_merge #(
    parameter int LINE_W = 256
) (
    input  logic [LINE_W-1:0]    old_line,
    input  logic [LINE_W-1:0]    new_line,
    input  logic [LINE_W/32-1:0] mask,
    output logic [LINE_W-1:0]    merged
);

    // Each mask bit selects the new word; cleared bits keep the old word
    for (genvar k = 0; k < LINE_W / 32; k++) begin : g_word
        assign merged[32*k +: 32] = mask[k] ? new_line[32*k +: 32] : old_line[32*k +: 32];
    end

endmodule

// File: rtl/dmem_model_pl.sv
// Latency-modelled backing memory: one line-sized read or write per request,
// answered with a single-cycle response after a fixed read or write latency.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; accepting latches it and starts the count
// WAIT  | latency count running; request inputs ignored
// RESP  | one-cycle response pulse; memory update happened on entry
module dmem_model_pl
    import dmem_pkg::*;
#(
    parameter int    LINE_W    = 256,
    parameter int    DEPTH     = 512,
    parameter int    ADDR_W    = 32,
    parameter int    RD_LAT    = 10,
    parameter int    WR_LAT    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [LINE_W-1:0]      req_data_i,
    input  logic [LINE_W/32-1:0]   req_wmask_i,
    output logic                   resp_valid_o,
    output logic [LINE_W-1:0]      resp_data_o,
    output logic                   resp_err_o
);

    localparam int WORDS  = LINE_W / 32;
    localparam int OFF_W  = offset_bits(LINE_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [31:0] RD_LAT_C = 32'(RD_LAT);
    localparam logic [31:0] WR_LAT_C = 32'(WR_LAT);

    state_t              state_q, state_d;
    logic                accept, enter_resp;
    logic                wr_q;
    logic [IDX_W-1:0]    idx_q;
    logic [LINE_W-1:0]   data_q;
    logic [WORDS-1:0]    mask_q;
    logic [31:0]         lat_q, cnt_q;
    logic                in_range;
    logic [MEM_AW-1:0]   mem_a;
    logic [LINE_W-1:0]   old_line, merged_line;
    logic [LINE_W-1:0]   resp_data_q;
    logic                resp_err_q;

    reg [LINE_W-1:0] mem [0:DEPTH-1];

    // Byte-offset bits never select anything
    logic unused_offset;
    assign unused_offset = ^req_addr_i[OFF_W-1:0];

    // Next-state decode; the response is entered once the count reaches the
    // latched latency, so it appears LAT edges after the accepting edge
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == lat_q) begin
                    enter_resp = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and latency counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= 32'd1;
            else if (state_q == WAIT)
                cnt_q <= cnt_q + 32'd1;
            else
                cnt_q <= '0;
        end
    end

    // Capture the accepted request for use at response time
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            mask_q <= '0;
            lat_q  <= '0;
        end else if (accept) begin
            wr_q   <= req_write_i;
            idx_q  <= req_addr_i[ADDR_W-1:OFF_W];
            data_q <= req_data_i;
            mask_q <= req_wmask_i;
            lat_q  <= req_write_i ? WR_LAT_C : RD_LAT_C;
        end
    end

    assign in_range = (idx_q < DEPTH_IDX);
    assign mem_a    = idx_q[MEM_AW-1:0];
    assign old_line = mem[mem_a];

    dmem_word_merge #(.LINE_W(LINE_W)) u_merge (
        .old_line (old_line),
        .new_line (data_q),
        .mask     (mask_q),
        .merged   (merged_line)
    );

    // Array update on entry to RESP; out-of-range writes are dropped
    always_ff @(posedge clk_i) begin
        if (enter_resp && wr_q && in_range && !rst_i)
            mem[mem_a] <= merged_line;
    end

    // Response data/error, held until the next response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (enter_resp) begin
            if (!in_range) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b1;
            end else begin
                resp_data_q <= wr_q ? merged_line : old_line;
                resp_err_q  <= 1'b0;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_model_pl.sv
// Bench for dmem_model_pl: two instances (10/10 and 1/3 latency) checked every
// cycle against a transaction-level model, plus literal directed checks.
module tb_dmem_model_pl;

    localparam int LW    = 256;
    localparam int NW    = LW / 32;
    localparam int DEPTH = 512;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_write [2];
    logic [31:0]   req_addr  [2];
    logic [LW-1:0] req_data  [2];
    logic [NW-1:0] req_wmask [2];
    logic          resp_valid[2];
    logic [LW-1:0] resp_data [2];
    logic          resp_err  [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit            m_busy[2];
    int            m_rem [2];
    bit            m_wr  [2];
    logic [31:0]   m_addr[2];
    logic [LW-1:0] m_data[2];
    logic [NW-1:0] m_mask[2];
    bit            e_valid[2];
    logic [LW-1:0] e_data [2];
    bit            e_err  [2];
    logic [LW-1:0] mm [2][8];

    // Clock
    always #5 clk_i = ~clk_i;

    dmem_model_pl #(.RD_LAT(10), .WR_LAT(10)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_write_i(req_write[0]), .req_addr_i(req_addr[0]),
        .req_data_i(req_data[0]), .req_wmask_i(req_wmask[0]),
        .resp_valid_o(resp_valid[0]), .resp_data_o(resp_data[0]),
        .resp_err_o(resp_err[0])
    );

    dmem_model_pl #(.RD_LAT(1), .WR_LAT(3)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_write_i(req_write[1]), .req_addr_i(req_addr[1]),
        .req_data_i(req_data[1]), .req_wmask_i(req_wmask[1]),
        .resp_valid_o(resp_valid[1]), .resp_data_o(resp_data[1]),
        .resp_err_o(resp_err[1])
    );

    function automatic int rd_lat(input int i);
        return (i == 0) ? 10 : 1;
    endfunction

    function automatic int wr_lat(input int i);
        return (i == 0) ? 10 : 3;
    endfunction

    function automatic logic [LW-1:0] merge_words(input logic [LW-1:0] o, input logic [LW-1:0] n,
                                                   input logic [NW-1:0] m);
        logic [LW-1:0] r;
        r = o;
        for (int k = 0; k < NW; k++)
            if (m[k]) r[32*k +: 32] = n[32*k +: 32];
        return r;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < NW; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // One model step per rising edge: a request accepted at edge E is answered
    // at edge E+LAT (pulse in the following cycle); ready only when idle
    task automatic model_step(input int i);
        bit rdy;
        int unsigned idx;
        if (rst_i) begin
            m_busy[i]  = 1'b0;
            e_valid[i] = 1'b0;
            e_data[i]  = '0;
            e_err[i]   = 1'b0;
            return;
        end
        rdy        = !m_busy[i] && !e_valid[i];
        e_valid[i] = 1'b0;
        if (m_busy[i]) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
                m_busy[i]  = 1'b0;
                e_valid[i] = 1'b1;
                idx = m_addr[i] >> 5;
                if (idx >= DEPTH) begin
                    e_data[i] = '0;
                    e_err[i]  = 1'b1;
                end else begin
                    if (m_wr[i]) mm[i][idx] = merge_words(mm[i][idx], m_data[i], m_mask[i]);
                    e_data[i] = mm[i][idx];
                    e_err[i]  = 1'b0;
                end
            end
        end
        if (rdy && req_valid[i]) begin
            m_busy[i] = 1'b1;
            m_rem[i]  = req_write[i] ? wr_lat(i) : rd_lat(i);
            m_wr[i]   = req_write[i];
            m_addr[i] = req_addr[i];
            m_data[i] = req_data[i];
            m_mask[i] = req_wmask[i];
        end
    endtask

    // Model advance on every rising edge
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_rem[i] = 0; e_valid[i] = 1'b0;
            e_data[i] = '0; e_err[i] = 1'b0;
        end
        forever begin
            @(posedge clk_i);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // Per-cycle comparison of all outputs of both instances
    initial begin
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < 2; i++) begin
                if (rst_i) begin
                    chk($sformatf("ready_rst[%0d]", i), LW'(req_ready[i]), LW'(1));
                    chk($sformatf("valid_rst[%0d]", i), LW'(resp_valid[i]), LW'(0));
                    chk($sformatf("data_rst[%0d]", i), resp_data[i], '0);
                    chk($sformatf("err_rst[%0d]", i), LW'(resp_err[i]), LW'(0));
                end else begin
                    chk($sformatf("ready[%0d]", i), LW'(req_ready[i]),
                        LW'(!m_busy[i] && !e_valid[i]));
                    chk($sformatf("valid[%0d]", i), LW'(resp_valid[i]), LW'(e_valid[i]));
                    chk($sformatf("data[%0d]", i), resp_data[i], e_data[i]);
                    chk($sformatf("err[%0d]", i), LW'(resp_err[i]), LW'(e_err[i]));
                end
            end
        end
    end

    // Issue one request, wait for acceptance and response; returns latency in cycles
    task automatic do_req(input int i, input bit wr, input logic [31:0] addr,
                          input logic [LW-1:0] data, input logic [NW-1:0] mask,
                          output int lat, output logic [LW-1:0] rd, output logic err);
        bit rdy;
        int n;
        req_write[i] = wr; req_addr[i] = addr; req_data[i] = data;
        req_wmask[i] = mask; req_valid[i] = 1'b1;
        rdy = 1'b0; n = 0;
        while (!rdy) begin
            rdy = req_ready[i];
            @(posedge clk_i); #1;
            n++;
            if (!rdy && n > 100) begin
                note_timeout("accept");
                break;
            end
        end
        req_valid[i] = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk_i);
            if (resp_valid[i]) break;
            lat++;
            if (lat > 100) begin
                note_timeout("response");
                break;
            end
        end
        rd  = resp_data[i];
        err = resp_err[i];
        @(posedge clk_i); #1;
    endtask

    task automatic rand_run(input int i, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int unsigned sel;
            req_valid[i] = ($urandom_range(0, 99) < 60);
            req_write[i] = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) begin
                sel = $urandom_range(0, 2);
                req_addr[i] = (sel == 0) ? 32'(512 * 32) :
                              (sel == 1) ? 32'(600 * 32 + 7) : 32'hFFFF_FFE0;
            end else begin
                req_addr[i] = 32'($urandom_range(0, 7) * 32 + $urandom_range(0, 31));
            end
            sel = $urandom_range(0, 9);
            req_wmask[i] = (sel == 0) ? '0 : (sel < 3) ? '1 : NW'($urandom);
            req_data[i]  = rand_line();
            @(posedge clk_i); #1;
        end
        req_valid[i] = 1'b0;
    endtask

    localparam logic [LW-1:0] L_A5   = {32{8'hA5}};
    localparam logic [LW-1:0] L_ONES = {NW{32'hFFFF_FFFF}};
    localparam logic [LW-1:0] L_11   = {NW{32'h1111_1111}};
    localparam logic [LW-1:0] L_MIX  = {{4{32'hFFFF_FFFF}}, {4{32'h1111_1111}}};
    localparam logic [LW-1:0] L_DEAD = {NW{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] L_1234 = {NW{32'h1234_5678}};

    // Directed then randomized stimulus
    initial begin
        int            lat, n, n2;
        logic [LW-1:0] rd;
        logic          err;
        bit            rdy, seen;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
            req_data[i] = '0; req_wmask[i] = '0;
        end
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Known contents for lines 0..7 of both instances
        for (int i = 0; i < 2; i++)
            for (int l = 0; l < 8; l++)
                do_req(i, 1'b1, 32'(l * 32), rand_line(), '1, lat, rd, err);

        // Read latency and data of a freshly written line
        do_req(0, 1'b1, 32'h60, L_A5, '1, lat, rd, err);
        do_req(0, 1'b0, 32'h60, '0, '0, lat, rd, err);
        chk("rd_lat10", LW'(lat), LW'(10));
        chk("rd_a5", rd, L_A5);
        chk("rd_a5_err", LW'(err), LW'(0));

        // Word-masked write over an all-ones line
        do_req(0, 1'b1, 32'h40, L_ONES, '1, lat, rd, err);
        do_req(0, 1'b1, 32'h40, L_11, 8'h0F, lat, rd, err);
        chk("wr_lat10", LW'(lat), LW'(10));
        chk("mask_wr_resp", rd, L_MIX);
        do_req(0, 1'b0, 32'h40, '0, '0, lat, rd, err);
        chk("mask_rd", rd, L_MIX);

        // Zero mask leaves the line alone but returns it
        do_req(0, 1'b1, 32'h40, '0, '0, lat, rd, err);
        chk("zero_mask_resp", rd, L_MIX);

        // Out-of-range read and write; line 0 must not alias index 512
        do_req(0, 1'b1, 32'h0, L_DEAD, '1, lat, rd, err);
        do_req(0, 1'b0, 32'(512 * 32), '0, '0, lat, rd, err);
        chk("oob_rd_err", LW'(err), LW'(1));
        chk("oob_rd_data", rd, '0);
        do_req(0, 1'b1, 32'(512 * 32), L_11, '1, lat, rd, err);
        chk("oob_wr_err", LW'(err), LW'(1));
        do_req(0, 1'b0, 32'h0, '0, '0, lat, rd, err);
        chk("oob_no_alias", rd, L_DEAD);
        chk("oob_no_alias_err", LW'(err), LW'(0));

        // Short latencies, back to back
        do_req(1, 1'b1, 32'h20, L_1234, '1, lat, rd, err);
        chk("fast_wr_lat3", LW'(lat), LW'(3));
        do_req(1, 1'b0, 32'h3F, '0, '0, lat, rd, err);
        chk("fast_rd_lat1", LW'(lat), LW'(1));
        chk("fast_rd_data", rd, L_1234);

        // Reset four cycles into a write aborts it
        req_write[0] = 1'b1; req_addr[0] = 32'h60; req_data[0] = '0;
        req_wmask[0] = '1; req_valid[0] = 1'b1;
        n = 0;
        do begin
            rdy = req_ready[0];
            @(posedge clk_i); #1;
            n++;
        end while (!rdy && n < 100);
        req_valid[0] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk_i); seen |= resp_valid[0];
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
        @(negedge clk_i); seen |= resp_valid[0];
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_no_resp", LW'(seen), LW'(0));
        @(negedge clk_i);
        chk("rst_ready", LW'(req_ready[0]), LW'(1));
        @(posedge clk_i); #1;
        do_req(0, 1'b0, 32'h60, '0, '0, lat, rd, err);
        chk("rst_line_kept", rd, L_A5);

        // Valid held through WAIT with a changed address: second served after RESP
        req_write[0] = 1'b0; req_addr[0] = 32'h60; req_valid[0] = 1'b1;
        n = 0;
        do begin
            rdy = req_ready[0];
            @(posedge clk_i); #1;
            n++;
        end while (!rdy && n < 100);
        req_addr[0] = 32'h40;
        n = 0;
        do begin
            @(negedge clk_i); n++;
        end while (!resp_valid[0] && n < 100);
        chk("hold_first_gap", LW'(n), LW'(11));
        chk("hold_first_data", resp_data[0], L_A5);
        n2 = 0;
        do begin
            @(negedge clk_i); n2++;
        end while (!resp_valid[0] && n2 < 100);
        chk("hold_second_gap", LW'(n2), LW'(12));
        chk("hold_second_data", resp_data[0], L_MIX);
        @(posedge clk_i); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        fork
            rand_run(0, 600);
            rand_run(1, 600);
        join
        repeat (15) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
